// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin two-port arbiter in front of one 32-bit read-before-write BRAM
module bram_arbiter #(
  parameter int ADR_WIDTH = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_adr,
  input  logic [31:0] p0_wdat,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdat,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_adr,
  input  logic [31:0] p1_wdat,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdat,
  output logic [15:0] mem_a,
  output logic [31:0] mem_do,
  output logic        mem_we,
  input  logic [31:0] mem_di
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
  state_t      r_state, w_next;
  logic        r_id, r_last, r_oor;
  logic [31:0] r_cap;
  logic        w_any, w_win, w_oor;
  logic [15:0] w_adr;
  always_comb begin
    w_any  = p0_req | p1_req;
    w_win  = (p0_req & p1_req) ? ~r_last : p1_req;
    w_adr  = w_win ? p1_adr : p0_adr;
    w_oor  = (w_adr >> ADR_WIDTH) != 16'd0;
    w_next = r_state == IDLE    ? (w_any ? ISSUE : IDLE) :
             r_state == ISSUE   ? CAPTURE :
             r_state == CAPTURE ? ACK : IDLE;
  end
  // read data is captured a cycle early and published together with ack so rdat only changes on ack
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_oor   <= 1'b0;
      r_cap   <= 32'd0;
      mem_a   <= 16'd0;
      mem_do  <= 32'd0;
      mem_we  <= 1'b0;
      p0_ack  <= 1'b0;
      p0_err  <= 1'b0;
      p0_rdat <= 32'd0;
      p1_ack  <= 1'b0;
      p1_err  <= 1'b0;
      p1_rdat <= 32'd0;
    end else begin
      r_state <= w_next;
      mem_we  <= 1'b0;
      p0_ack  <= 1'b0;
      p0_err  <= 1'b0;
      p1_ack  <= 1'b0;
      p1_err  <= 1'b0;
      if (r_state == IDLE && w_any) begin
        r_id   <= w_win;
        r_last <= w_win;
        r_oor  <= w_oor;
        mem_a  <= w_adr;
        mem_do <= w_win ? p1_wdat : p0_wdat;
        mem_we <= (w_win ? p1_we : p0_we) & ~w_oor;
      end
      if (r_state == CAPTURE) r_cap <= r_oor ? 32'd0 : mem_di;
      if (r_state == ACK && r_id) begin
        p1_ack  <= 1'b1;
        p1_err  <= r_oor;
        p1_rdat <= r_cap;
      end
      if (r_state == ACK && !r_id) begin
        p0_ack  <= 1'b1;
        p0_err  <= r_oor;
        p0_rdat <= r_cap;
      end
    end
  end
endmodule
